// File: rtl/icmp_echo_buf.sv
// Single-packet ICMP echo buffer: captures a received payload into a byte RAM,
// requests one reply frame and streams the stored bytes back on tx_req.
module icmp_echo_buf #(
    parameter int unsigned AW = 11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rec_en,
    input  logic [7:0]  rec_data,
    input  logic        rec_pkt_done,
    input  logic [15:0] rec_byte_num,
    input  logic        tx_req,
    input  logic        tx_done,
    output logic        tx_start_en,
    output logic [7:0]  tx_data,
    output logic [15:0] tx_byte_num,
    output logic        busy,
    output logic [15:0] drop_cnt
);

    localparam int unsigned DEPTH   = 1 << AW;
    localparam logic [16:0] DEPTH_W = 17'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_SEND
    } state_e;

    state_e      state_q;
    logic [AW:0] wr_ptr_q;
    logic [AW:0] rd_ptr_q;
    logic        ovf_q;
    logic        tx_start_q;
    logic [15:0] tx_num_q;
    logic        busy_q;
    logic [15:0] drop_q;
    logic        zero_q;
    logic [7:0]  ram_q;
    logic [7:0]  mem [DEPTH];

    logic wr_full_c;
    logic wr_en_c;
    logic rd_in_range_c;
    logic rd_en_c;
    logic pkt_bad_c;
    logic drop_inc_c;

    // Pointer status and packet accept/discard decisions
    always_comb begin
        wr_full_c     = wr_ptr_q[AW];
        wr_en_c       = (state_q == S_IDLE) && rec_en && !wr_full_c;
        rd_in_range_c = 16'(rd_ptr_q) < tx_num_q;
        rd_en_c       = (state_q == S_SEND) && tx_req && rd_in_range_c;
        pkt_bad_c     = (rec_byte_num == 16'd0)
                     || ({1'b0, rec_byte_num} > DEPTH_W)
                     || ovf_q
                     || (rec_en && wr_full_c);
        drop_inc_c    = rec_pkt_done && ((state_q != S_IDLE) || pkt_bad_c);
    end

    // Control FSM with registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            ovf_q      <= 1'b0;
            tx_start_q <= 1'b0;
            tx_num_q   <= 16'd0;
            busy_q     <= 1'b0;
            drop_q     <= 16'd0;
            zero_q     <= 1'b1;
        end else begin
            tx_start_q <= 1'b0;
            if (drop_inc_c && (drop_q != 16'hFFFF)) begin
                drop_q <= drop_q + 16'd1;
            end
            case (state_q)
                S_IDLE: begin
                    if (rec_en) begin
                        if (wr_full_c) begin
                            ovf_q <= 1'b1;
                        end else begin
                            wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
                        end
                    end
                    // Closing a packet always rewinds the write side, accepted or not
                    if (rec_pkt_done) begin
                        wr_ptr_q <= '0;
                        ovf_q    <= 1'b0;
                        if (!pkt_bad_c) begin
                            tx_num_q   <= rec_byte_num;
                            rd_ptr_q   <= '0;
                            tx_start_q <= 1'b1;
                            busy_q     <= 1'b1;
                            state_q    <= S_START;
                        end
                    end
                end
                S_START: begin
                    state_q <= S_SEND;
                end
                S_SEND: begin
                    if (tx_req) begin
                        if (rd_in_range_c) begin
                            rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
                        end
                        zero_q <= !rd_in_range_c;
                    end
                    if (tx_done) begin
                        rd_ptr_q <= '0;
                        busy_q   <= 1'b0;
                        state_q  <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Simple dual-port byte RAM; no reset so it maps onto block RAM
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            mem[wr_ptr_q[AW-1:0]] <= rec_data;
        end
        if (rd_en_c) begin
            ram_q <= mem[rd_ptr_q[AW-1:0]];
        end
    end

    assign tx_start_en = tx_start_q;
    assign tx_data     = zero_q ? 8'h00 : ram_q;
    assign tx_byte_num = tx_num_q;
    assign busy        = busy_q;
    assign drop_cnt    = drop_q;

endmodule

// File: tb/tb_icmp_echo_buf.sv
// Self-checking bench for icmp_echo_buf: vector table, directed corner cases
// and randomized packets against a transaction-level echo model.
module tb_icmp_echo_buf;

    localparam int DEPTH = 2048;

    logic        clk;
    logic        rst;
    logic        rec_en;
    logic [7:0]  rec_data;
    logic        rec_pkt_done;
    logic [15:0] rec_byte_num;
    logic        tx_req;
    logic        tx_done;
    logic        tx_start_en;
    logic [7:0]  tx_data;
    logic [15:0] tx_byte_num;
    logic        busy;
    logic [15:0] drop_cnt;

    icmp_echo_buf #(.AW(11)) dut (
        .clk          (clk),
        .rst          (rst),
        .rec_en       (rec_en),
        .rec_data     (rec_data),
        .rec_pkt_done (rec_pkt_done),
        .rec_byte_num (rec_byte_num),
        .tx_req       (tx_req),
        .tx_done      (tx_done),
        .tx_start_en  (tx_start_en),
        .tx_data      (tx_data),
        .tx_byte_num  (tx_byte_num),
        .busy         (busy),
        .drop_cnt     (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #20000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        en;
        logic [7:0]  d;
        logic        done;
        logic [15:0] num;
        logic        req;
        logic        txd;
        logic        e_start;
        logic        e_busy;
        logic [7:0]  e_data;
        logic [15:0] e_num;
        logic [15:0] e_drop;
    } vec_t;

    vec_t tbl [15];

    int n_tests = 0;
    int n_fail  = 0;

    // Transaction-level model state
    logic [7:0] mem_m [DEPTH];
    logic [7:0] pkt [$];
    int         m_drop;
    bit         m_idle;
    int         m_num;
    int         m_rd;
    logic [7:0] m_data;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        rec_en       = 1'b0;
        rec_data     = 8'h00;
        rec_pkt_done = 1'b0;
        rec_byte_num = 16'd0;
        tx_req       = 1'b0;
        tx_done      = 1'b0;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Deliver pkt[] then close it with rec_byte_num=num; returns whether a reply was started
    task automatic feed(input int num, input bit merge_last, input int gap_pct, output bit acc);
        int wp;
        bit was_idle;
        wp = 0;
        was_idle = m_idle;
        for (int i = 0; i < pkt.size(); i++) begin
            while ($urandom_range(99) < gap_pct) begin
                clr();
                step();
            end
            clr();
            rec_en   = 1'b1;
            rec_data = pkt[i];
            if (was_idle) begin
                if (wp < DEPTH) mem_m[wp] = pkt[i];
                wp++;
            end
            if (merge_last && (i == pkt.size() - 1)) begin
                rec_pkt_done = 1'b1;
                rec_byte_num = 16'(num);
            end
            step();
        end
        if (!merge_last || pkt.size() == 0) begin
            clr();
            rec_pkt_done = 1'b1;
            rec_byte_num = 16'(num);
            step();
        end
        clr();
        acc = was_idle && (num != 0) && (num <= DEPTH) && (pkt.size() <= DEPTH);
        if (!acc) m_drop++;
        check("start_pulse", 32'(tx_start_en), 32'(acc));
        check("drop_cnt", 32'(drop_cnt), 32'(m_drop));
        if (acc) begin
            check("busy_rise", 32'(busy), 32'd1);
            check("tx_byte_num", 32'(tx_byte_num), 32'(num));
            m_idle = 1'b0;
            m_num  = num;
            m_rd   = 0;
            step();
            check("start_single", 32'(tx_start_en), 32'd0);
        end
    endtask

    // Issue nreq tx_req cycles and check each byte one cycle later
    task automatic drain(input int nreq, input int gap_pct, input bit finish);
        logic [7:0] e;
        for (int k = 0; k < nreq; k++) begin
            while ($urandom_range(99) < gap_pct) begin
                clr();
                step();
                check("data_hold", 32'(tx_data), 32'(m_data));
            end
            clr();
            tx_req = 1'b1;
            step();
            clr();
            if (m_rd < m_num) begin
                e = mem_m[m_rd];
                m_rd++;
            end else begin
                e = 8'h00;
            end
            m_data = e;
            check("echo_data", 32'(tx_data), 32'(e));
        end
        check("busy_send", 32'(busy), 32'd1);
        check("num_held", 32'(tx_byte_num), 32'(m_num));
        if (finish) begin
            tx_done = 1'b1;
            step();
            clr();
            check("busy_fall", 32'(busy), 32'd0);
            m_idle = 1'b1;
            m_rd   = 0;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_start"}, 32'(tx_start_en), 32'd0);
        check({tag, "_data"},  32'(tx_data),     32'd0);
        check({tag, "_num"},   32'(tx_byte_num), 32'd0);
        check({tag, "_busy"},  32'(busy),        32'd0);
        check({tag, "_drop"},  32'(drop_cnt),    32'd0);
    endtask

    initial begin
        bit acc;
        int len;
        int sel;
        int num;

        // 4-byte packet AA..DD, over-request by 2, stray tx_done/tx_req outside SEND
        tbl[0]  = '{1'b1, 8'hAA, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 16'd0, 16'd0};
        tbl[1]  = '{1'b1, 8'hBB, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 16'd0, 16'd0};
        tbl[2]  = '{1'b1, 8'hCC, 1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 16'd0, 16'd0};
        tbl[3]  = '{1'b1, 8'hDD, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 16'd0, 16'd0};
        tbl[4]  = '{1'b0, 8'h00, 1'b1, 16'd4, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 16'd4, 16'd0};
        tbl[5]  = '{1'b0, 8'h00, 1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 16'd4, 16'd0};
        tbl[6]  = '{1'b0, 8'h00, 1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b1, 8'hAA, 16'd4, 16'd0};
        tbl[7]  = '{1'b0, 8'h00, 1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b1, 8'hBB, 16'd4, 16'd0};
        tbl[8]  = '{1'b0, 8'h00, 1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b1, 8'hCC, 16'd4, 16'd0};
        tbl[9]  = '{1'b0, 8'h00, 1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b1, 8'hDD, 16'd4, 16'd0};
        tbl[10] = '{1'b0, 8'h00, 1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 16'd4, 16'd0};
        tbl[11] = '{1'b0, 8'h00, 1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 16'd4, 16'd0};
        tbl[12] = '{1'b0, 8'h00, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 16'd4, 16'd0};
        tbl[13] = '{1'b0, 8'h00, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 16'd4, 16'd0};
        tbl[14] = '{1'b0, 8'h00, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 16'd4, 16'd0};

        for (int i = 0; i < DEPTH; i++) mem_m[i] = 8'h00;
        m_drop = 0;
        m_idle = 1'b1;
        m_num  = 0;
        m_rd   = 0;
        m_data = 8'h00;

        clr();
        rst = 1'b1;
        step();
        step();
        check_reset_outputs("reset");
        rst = 1'b0;

        for (int i = 0; i < 15; i++) begin
            rec_en       = tbl[i].en;
            rec_data     = tbl[i].d;
            rec_pkt_done = tbl[i].done;
            rec_byte_num = tbl[i].num;
            tx_req       = tbl[i].req;
            tx_done      = tbl[i].txd;
            step();
            check($sformatf("vec%0d_start", i), 32'(tx_start_en), 32'(tbl[i].e_start));
            check($sformatf("vec%0d_busy", i),  32'(busy),        32'(tbl[i].e_busy));
            check($sformatf("vec%0d_data", i),  32'(tx_data),     32'(tbl[i].e_data));
            check($sformatf("vec%0d_num", i),   32'(tx_byte_num), 32'(tbl[i].e_num));
            check($sformatf("vec%0d_drop", i),  32'(drop_cnt),    32'(tbl[i].e_drop));
        end
        clr();
        m_data = 8'h00;

        // Basic 32-byte echo with a second packet arriving mid-reply
        pkt.delete();
        for (int i = 0; i < 32; i++) pkt.push_back(8'(i));
        feed(32, 1'b0, 0, acc);
        drain(10, 0, 1'b0);
        pkt.delete();
        for (int i = 0; i < 16; i++) pkt.push_back(8'(8'h80 + i));
        feed(16, 1'b0, 0, acc);
        check("busy_drop_cnt", 32'(drop_cnt), 32'd1);
        drain(22, 0, 1'b1);

        // Oversize packet, then zero-length close, then a good 4-byte packet
        pkt.delete();
        for (int i = 0; i < DEPTH + 1; i++) pkt.push_back(8'(i));
        feed(DEPTH + 1, 1'b0, 0, acc);
        pkt.delete();
        feed(0, 1'b0, 0, acc);
        check("oversize_drop_cnt", 32'(drop_cnt), 32'd3);
        pkt = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        feed(4, 1'b0, 0, acc);
        drain(6, 0, 1'b1);

        // Reset in the middle of a reply
        pkt.delete();
        for (int i = 0; i < 8; i++) pkt.push_back(8'(8'h10 + i));
        feed(8, 1'b0, 0, acc);
        drain(2, 0, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_reset_outputs("midrst");
        m_drop = 0;
        m_idle = 1'b1;
        m_rd   = 0;
        m_data = 8'h00;
        for (int i = 0; i < 3; i++) begin
            step();
            check("midrst_no_start", 32'(tx_start_en), 32'd0);
        end
        pkt.delete();
        for (int i = 0; i < 5; i++) pkt.push_back(8'(8'h50 + i));
        feed(5, 1'b0, 0, acc);
        drain(5, 0, 1'b1);

        // Last byte coincides with rec_pkt_done
        pkt.delete();
        for (int i = 0; i < 8; i++) pkt.push_back(8'(8'hE0 + i));
        feed(8, 1'b1, 0, acc);
        drain(8, 0, 1'b1);

        // Randomized packets with gaps, length mismatches and busy-time arrivals
        for (int it = 0; it < 40; it++) begin
            len = int'($urandom_range(0, 24));
            pkt.delete();
            for (int i = 0; i < len; i++) pkt.push_back(8'($urandom));
            sel = int'($urandom_range(0, 9));
            if (sel <= 5)      num = len;
            else if (sel == 6) num = 0;
            else if (sel == 7) num = int'($urandom_range(1, 64));
            else               num = DEPTH + int'($urandom_range(1, 3));
            feed(num, 1'($urandom_range(0, 1)), 25, acc);
            if (acc) begin
                if ($urandom_range(0, 3) == 0) begin
                    pkt.delete();
                    for (int i = 0; i < 5; i++) pkt.push_back(8'($urandom));
                    feed(5, 1'b0, 20, acc);
                end
                drain(m_num + int'($urandom_range(0, 2)), 30, 1'b1);
            end else begin
                for (int i = 0; i < int'($urandom_range(0, 2)); i++) step();
            end
        end
        check("final_drop_cnt", 32'(drop_cnt), 32'(m_drop));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/icmp_echo_buf.md
# icmp_echo_buf

Single-packet echo buffer between the ICMP receive path and the ICMP transmit path. Captures the payload bytes delivered on the receive user interface (rec_en/rec_data/rec_pkt_done/rec_byte_num) into an internal byte RAM. It then requests one reply frame with tx_start_en and streams the stored bytes back on tx_data in response to tx_req. Used by the ping-echo top level so that echo-request payloads are returned unchanged.

## Interface
Parameters:
- AW, 11, buffer address width; DEPTH = 2^AW bytes (default 2048).

Ports:
- clk  in  1  single clock; the GMII clock feeding both ICMP rx and tx paths.
- rst  in  1  synchronous, active-high reset.
- rec_en  in  1  received payload byte valid.
- rec_data  in  8  received payload byte.
- rec_pkt_done  in  1  one-cycle pulse; packet receive complete.
- rec_byte_num  in  16  valid payload byte count; sampled when rec_pkt_done is high.
- tx_req  in  1  transmit path requests the next payload byte.
- tx_done  in  1  one-cycle pulse; reply frame fully sent.
- tx_start_en  out  1  one-cycle pulse; start the reply frame.
- tx_data  out  8  payload byte to transmit.
- tx_byte_num  out  16  reply payload length; held stable from tx_start_en until tx_done.
- busy  out  1  high in START and SEND states.
- drop_cnt  out  16  count of discarded packets; saturates at 16'hFFFF.

## Operation
- States:
  - IDLE: accepting packet.
  - START: issue request.
  - SEND: serving tx_req.
- IDLE:
  - Each rec_en writes rec_data to RAM[wr_ptr] and increments wr_ptr.
  - Writes with wr_ptr ≥ DEPTH are not performed; an overflow flag is set instead.
- rec_pkt_done in IDLE:
  - Discard the packet (drop_cnt+1, wr_ptr←0, overflow←0, stay IDLE) if rec_byte_num == 0, rec_byte_num > DEPTH, or the overflow flag is set.
  - Otherwise latch tx_byte_num ← rec_byte_num, set wr_ptr←0 and rd_ptr←0, and go to START.
- START: drive tx_start_en=1 for exactly one cycle, then go to SEND.
- SEND:
  - Each tx_req cycle reads RAM[rd_ptr] and increments rd_ptr.
  - tx_req arriving once rd_ptr ≥ tx_byte_num yields tx_data=8'h00 and rd_ptr does not advance.
  - tx_done returns the block to IDLE; rd_ptr←0.
- Receive traffic while not in IDLE:
  - rec_en is ignored (no RAM write).
  - rec_pkt_done increments drop_cnt.
- rec_en and rec_pkt_done in the same cycle while in IDLE: the byte is written first, then the packet is closed using rec_byte_num.
- tx_req or tx_done outside SEND is ignored.
- Width rules:
  - wr_ptr and rd_ptr are AW+1 bits, so DEPTH itself is representable.
  - The comparison against rec_byte_num zero-extends the pointer to 16 bits.

## Timing
- Reset values:
  - Outputs: tx_start_en=0, tx_data=8'h00, tx_byte_num=16'd0, busy=0, drop_cnt=16'd0.
  - State=IDLE; wr_ptr, rd_ptr and the overflow flag are cleared.
- Reset mid-operation: the current packet is abandoned and no tx_start_en is issued afterwards. RAM contents need not be cleared.
- Start latency:
  - rec_pkt_done at cycle N → state START at N+1 → tx_start_en high at N+1 only.
  - busy goes high at N+1.
- Read latency: tx_req high at cycle M → tx_data valid (registered RAM read) at M+1 and held until the next tx_req result.
- Back-to-back tx_req on consecutive cycles delivers consecutive bytes on consecutive cycles.
- busy falls on the cycle after tx_done is sampled. A new packet is accepted from that cycle onward.
- RAM: one write port and one read port, both synchronous. Infers block RAM.

## Test plan
- Basic echo:
  - Stimulus: 32 bytes 0x00..0x1F, then rec_pkt_done with rec_byte_num=32.
  - Required: tx_start_en is a single pulse one cycle later and tx_byte_num=32.
  - Then 32 consecutive tx_req cycles; tx_data is 0x00..0x1F, each one cycle after its tx_req. tx_done then returns busy=0.
- Busy drop:
  - Stimulus: while in SEND, a second 16-byte packet plus rec_pkt_done arrives.
  - Required: drop_cnt=1, the first reply's data is unaltered, and no second tx_start_en.
- Oversize:
  - Stimulus: DEPTH+1 bytes with rec_byte_num=DEPTH+1; then rec_pkt_done with rec_byte_num=0.
  - Required: no tx_start_en for either; drop_cnt=2.
  - A following 4-byte packet (AA BB CC DD) echoes correctly, confirming wr_ptr was reset.
- Over-request: 4-byte packet, 6 tx_req cycles → tx_data AA BB CC DD 00 00.
- Reset mid-SEND:
  - Stimulus: rst asserted after 2 tx_req cycles.
  - Required: all outputs at reset values the next cycle. A new packet then echoes from its byte 0.
- Simultaneous last byte: the final rec_en coincides with rec_pkt_done (rec_byte_num=8) → all 8 bytes echo, including the last one.
